// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues PCs to a one-cycle-latency ROM, queues returned
// words in a small FIFO, and serves them to decode over valid/ready with branch flush.
module fetch_unit #(
  parameter int          QDEPTH     = 2,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          PROG_WORDS = 5
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_pc,
  input  logic [31:0] rom_inst,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted
);

  localparam int          PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int          CW     = $clog2(QDEPTH + 1);
  localparam logic [31:0] PROG_W = 32'(PROG_WORDS);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_mem_q [QDEPTH];
  logic [31:0]   pc_mem_q   [QDEPTH];

  logic          in_range;
  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occ;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_range  = ({2'b00, fetch_pc_q[31:2]} < PROG_W);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A word returns for every cycle inflight was set; the branch edge discards it.
  assign push      = inflight_q & ~branch_valid;
  // Occupancy after this edge if another read were launched; pop <= count, so no underflow.
  assign occ       = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue     = ~branch_valid & in_range & (occ < (CW+1)'(QDEPTH));

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (branch_valid) begin
      fetch_pc_d = branch_target & ~32'h3;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
      if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
      if (push) wr_ptr_d = ptr_next(wr_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue storage carries no reset; outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= rom_inst;
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign rom_pc   = fetch_pc_q;
  assign out_inst = out_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign out_pc   = out_valid ? pc_mem_q[rd_ptr_q]   : '0;
  assign halted   = ~in_range & ~inflight_q & (count_q == '0);

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == CW'(QDEPTH))));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: models the registered instruction ROM and checks
// per-cycle outputs from a vector table plus an asynchronous-reset sequence.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_pc;
  logic [31:0] rom_inst;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] P0 = 32'hE3A02005;
  localparam logic [31:0] P1 = 32'hE52D2004;
  localparam logic [31:0] P2 = 32'hE52D2004;
  localparam logic [31:0] P3 = 32'hE49D3004;
  localparam logic [31:0] P4 = 32'hE49D4004;

  fetch_unit #(.QDEPTH(2), .RESET_PC(32'h0), .PROG_WORDS(5)) dut (
    .clk(clk), .rst(rst), .rom_pc(rom_pc), .rom_inst(rom_inst),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // ROM: one-cycle registered read, zero in reset, junk outside the image
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rom_inst <= '0;
    else begin
      case (rom_pc)
        32'd0:   rom_inst <= P0;
        32'd4:   rom_inst <= P1;
        32'd8:   rom_inst <= P2;
        32'd12:  rom_inst <= P3;
        32'd16:  rom_inst <= P4;
        default: rom_inst <= 32'hDEADBEEF;
      endcase
    end
  end

  typedef struct {
    bit          rst_pre;
    bit          rdy;
    bit          br;
    logic [31:0] tgt;
    bit          ev;
    logic [31:0] einst;
    logic [31:0] epc;
    bit          eh;
    logic [31:0] erp;
  } vec_t;

  function automatic vec_t mk(bit rp, bit rdy, bit br, logic [31:0] tgt, bit ev,
                              logic [31:0] ei, logic [31:0] ep, bit eh, logic [31:0] erp);
    vec_t v;
    v.rst_pre = rp; v.rdy = rdy; v.br = br; v.tgt = tgt; v.ev = ev;
    v.einst = ei; v.epc = ep; v.eh = eh; v.erp = erp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit ev, input logic [31:0] ei,
                            input logic [31:0] ep, input bit eh, input logic [31:0] erp);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, ".out_inst"},  out_inst, ei);
    chk({tag, ".out_pc"},    out_pc, ep);
    chk({tag, ".halted"},    {31'd0, halted}, {31'd0, eh});
    chk({tag, ".rom_pc"},    rom_pc, erp);
  endtask

  task automatic do_reset();
    rst = 1'b1; branch_valid = 1'b0; branch_target = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    check_outs("reset", 1'b0, '0, '0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    // 1: free-running delivery then halt
    vecs.push_back(mk(1,1,0,0, 0,0,0,0,4));
    vecs.push_back(mk(0,1,0,0, 1,P0,0,0,8));
    vecs.push_back(mk(0,1,0,0, 1,P1,4,0,12));
    vecs.push_back(mk(0,1,0,0, 1,P2,8,0,16));
    vecs.push_back(mk(0,1,0,0, 1,P3,12,0,20));
    vecs.push_back(mk(0,1,0,0, 1,P4,16,0,20));
    vecs.push_back(mk(0,1,0,0, 0,0,0,1,20));
    vecs.push_back(mk(0,1,0,0, 0,0,0,1,20));
    // 2: back-pressure fills the queue, then drain
    vecs.push_back(mk(1,0,0,0, 0,0,0,0,4));
    vecs.push_back(mk(0,0,0,0, 1,P0,0,0,8));
    vecs.push_back(mk(0,0,0,0, 1,P0,0,0,8));
    vecs.push_back(mk(0,0,0,0, 1,P0,0,0,8));
    vecs.push_back(mk(0,1,0,0, 1,P1,4,0,12));
    vecs.push_back(mk(0,1,0,0, 1,P2,8,0,16));
    vecs.push_back(mk(0,1,0,0, 1,P3,12,0,20));
    vecs.push_back(mk(0,1,0,0, 1,P4,16,0,20));
    vecs.push_back(mk(0,1,0,0, 0,0,0,1,20));
    // 3: branch to unaligned 0xD after pc 0 accepted
    vecs.push_back(mk(1,1,0,0, 0,0,0,0,4));
    vecs.push_back(mk(0,1,0,0, 1,P0,0,0,8));
    vecs.push_back(mk(0,1,0,0, 1,P1,4,0,12));
    vecs.push_back(mk(0,0,1,32'hD, 0,0,0,0,12));
    vecs.push_back(mk(0,1,0,0, 0,0,0,0,16));
    vecs.push_back(mk(0,1,0,0, 1,P3,12,0,20));
    vecs.push_back(mk(0,1,0,0, 1,P4,16,0,20));
    vecs.push_back(mk(0,1,0,0, 0,0,0,1,20));
    // 4: branch with pop and capture on one edge, then branch to 0 from halt
    vecs.push_back(mk(1,1,0,0, 0,0,0,0,4));
    vecs.push_back(mk(0,1,0,0, 1,P0,0,0,8));
    vecs.push_back(mk(0,1,1,32'h14, 0,0,0,1,20));
    vecs.push_back(mk(0,1,1,32'h0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0, 0,0,0,0,4));
    vecs.push_back(mk(0,1,0,0, 1,P0,0,0,8));
    vecs.push_back(mk(0,1,0,0, 1,P1,4,0,12));
    vecs.push_back(mk(0,1,0,0, 1,P2,8,0,16));
    vecs.push_back(mk(0,1,0,0, 1,P3,12,0,20));
    vecs.push_back(mk(0,1,0,0, 1,P4,16,0,20));
    vecs.push_back(mk(0,1,0,0, 0,0,0,1,20));
    // 5: branch out of range
    vecs.push_back(mk(1,1,0,0, 0,0,0,0,4));
    vecs.push_back(mk(0,1,0,0, 1,P0,0,0,8));
    vecs.push_back(mk(0,0,1,32'h40, 0,0,0,1,32'h40));
    vecs.push_back(mk(0,1,0,0, 0,0,0,1,32'h40));
    vecs.push_back(mk(0,1,0,0, 0,0,0,1,32'h40));

    foreach (vecs[i]) begin
      if (vecs[i].rst_pre) do_reset();
      out_ready     = vecs[i].rdy;
      branch_valid  = vecs[i].br;
      branch_target = vecs[i].tgt;
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].einst, vecs[i].epc,
                 vecs[i].eh, vecs[i].erp);
    end

    // 6: asynchronous reset mid-stream
    do_reset();
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_outs("pre_arst", 1'b1, P1, 32'd4, 1'b0, 32'd12);
    #2 rst = 1'b1;
    #1 check_outs("arst_now", 1'b0, '0, '0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_outs("arst_e1", 1'b0, '0, '0, 1'b0, 32'd4);
    @(posedge clk); #1;
    check_outs("arst_e2", 1'b1, P0, 32'd0, 1'b0, 32'd8);
    @(posedge clk); #1;
    check_outs("arst_e3", 1'b1, P1, 32'd4, 1'b0, 32'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
